// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP inference pipeline: class count, fp32
// helpers and the arg-max state encoding.
package mlp_pkg;

   localparam int NUM_CLASSES = 10;

   // Canonical quiet NaN, reported as the winner when an image has no numbers.
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } argmax_state_t;

   // NaN: all-ones exponent with a nonzero mantissa. Infinities are not NaN.
   function automatic logic fp32_is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Maps an fp32 word onto an unsigned key whose ordering matches the
   // numeric ordering. Negatives are bit-inverted so larger magnitudes sort
   // lower; positives get the sign bit set so they sort above every negative.
   // -0 is folded onto +0 first so the two zeros compare equal.
   function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
      logic [31:0] n;
      n = (x == 32'h8000_0000) ? 32'h0000_0000 : x;
      return n[31] ? ~n : (n ^ 32'h8000_0000);
   endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict greater-than on two fp32 words. NaN inputs are not
// filtered here; the caller decides what a NaN means for its datapath.
module fp32_gt (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        gt
);
   import mlp_pkg::*;

   logic [31:0] key_a;
   logic [31:0] key_b;

   // Order keys for both operands, compared as plain unsigned integers.
   always_comb begin
      key_a = fp32_order_key(a);
      key_b = fp32_order_key(b);
      gt    = key_a > key_b;
   end

endmodule

// File: rtl/fp32_argmax.sv
// Streaming arg-max over one image worth of fp32 class scores. Keeps a
// registered best-so-far (value, index) pair and publishes it with a one-cycle
// done pulse after the last class has been accepted.
module fp32_argmax #(
   parameter int NUM_CLASSES = mlp_pkg::NUM_CLASSES,
   parameter int IDX_W       = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] index_pred,
   output logic [31:0]      max_value,
   output logic             nan_seen
);
   import mlp_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   argmax_state_t    state;
   logic [IDX_W-1:0] cnt;
   logic [31:0]      best_val;
   logic [IDX_W-1:0] best_idx;
   logic             best_valid;
   logic             nan_flag;

   logic             accept;
   logic             in_nan;
   logic             in_gt_best;
   logic             take;
   logic             last_accept;

   logic [IDX_W-1:0] cnt_d;
   logic [31:0]      best_val_d;
   logic [IDX_W-1:0] best_idx_d;
   logic             best_valid_d;
   logic             nan_flag_d;

   fp32_gt u_gt (
      .a  (in_data),
      .b  (best_val),
      .gt (in_gt_best)
   );

   // in_ready is only ever high in ACCUM, so this also gates by state.
   assign accept      = in_valid && in_ready;
   assign in_nan      = fp32_is_nan(in_data);
   // Strictly greater keeps the earlier index on ties; the first non-NaN
   // score always loads, which covers class 0 and images that open with NaNs.
   assign take        = accept && !in_nan && (!best_valid || in_gt_best);
   assign last_accept = accept && !start && (cnt == LAST_IDX);

   // Next best-so-far state: start clears it, an accepted score may replace it.
   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d        = cnt;
      best_val_d   = best_val;
      best_idx_d   = best_idx;
      best_valid_d = best_valid;
      nan_flag_d   = nan_flag;
      if (start) begin
         cnt_d        = '0;
         best_val_d   = FP32_QNAN;
         best_idx_d   = '0;
         best_valid_d = 1'b0;
         nan_flag_d   = 1'b0;
      end else if (accept) begin
         if (cnt != LAST_IDX) cnt_d = cnt + IDX_W'(1);
         if (in_nan) nan_flag_d = 1'b1;
         if (take) begin
            best_val_d   = in_data;
            best_idx_d   = cnt;
            best_valid_d = 1'b1;
         end
      end
   end

   // Best-so-far and class counter registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         best_val   <= FP32_QNAN;
         best_idx   <= '0;
         best_valid <= 1'b0;
         nan_flag   <= 1'b0;
      end else begin
         cnt        <= cnt_d;
         best_val   <= best_val_d;
         best_idx   <= best_idx_d;
         best_valid <= best_valid_d;
         nan_flag   <= nan_flag_d;
      end
   end

   // Control FSM with registered handshake, status and result outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         index_pred <= '0;
         max_value  <= '0;
         nan_seen   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               // A start here aborts the image; the counter and best pair are
               // cleared by the datapath and the published result is kept.
               if (last_accept) begin
                  state      <= DONE;
                  in_ready   <= 1'b0;
                  done       <= 1'b1;
                  index_pred <= best_idx_d;
                  max_value  <= best_val_d;
                  nan_seen   <= nan_flag_d;
               end
            end
            DONE: begin
               if (start) begin
                  state    <= ACCUM;
                  in_ready <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_argmax.sv
// Directed bench for fp32_argmax: each task drives one scenario and checks
// the published result against hand-computed values.
module tb_fp32_argmax;

   localparam int N = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic [3:0]  index_pred;
   logic [31:0] max_value;
   logic        nan_seen;

   int checks   = 0;
   int failures = 0;

   logic [31:0] img [N];

   fp32_argmax #(.NUM_CLASSES(N), .IDX_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .busy       (busy),
      .done       (done),
      .index_pred (index_pred),
      .max_value  (max_value),
      .nan_seen   (nan_seen)
   );

   always #5 clk = ~clk;

   // One-cycle start pulse; returns at the first ACCUM cycle with in_valid low.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   // Feeds img[0..n-1], optionally with random gaps. Returns one negedge after
   // the n-th accept with in_valid low.
   task automatic feed(input int n, input bit gaps, input string tag);
      int  i = 0;
      int  cyc = 0;
      bit  early = 1'b0;
      while (i < n && cyc < 300) begin
         @(negedge clk);
         if (done) early = 1'b1;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_data  = img[i];
         end
         if (in_valid && in_ready) i++;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      checks++;
      if (i != n) begin
         failures++;
         $display("FAIL %s_accepts: got %0d want %0d within cycle budget", tag, i, n);
      end
      checks++;
      if (early) begin
         failures++;
         $display("FAIL %s_early_done: got done=1 during collection want 0", tag);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, busy, done, nan_seen} !== 4'b0000 || index_pred !== 4'd0 || max_value !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b busy=%b done=%b nan=%b idx=%0d max=%h want all zero",
                  in_ready, busy, done, nan_seen, index_pred, max_value);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_release: got rdy=%b busy=%b done=%b want 000", in_ready, busy, done);
      end
   endtask

   task automatic test_basic();
      img = '{32'h3DCC_CCCD, 32'h3F00_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000,
              32'h4000_0000, 32'h3E80_0000, 32'hBF80_0000, 32'h3FC0_0000, 32'h4020_0000};
      pulse_start();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL start_ready: got rdy=%b busy=%b want 11", in_ready, busy);
      end
      feed(N, 1'b0, "basic");
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_done: got done=%b rdy=%b busy=%b want 101", done, in_ready, busy);
      end
      checks++;
      if (index_pred !== 4'd2 || max_value !== 32'h4040_0000 || nan_seen !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: got idx=%0d max=%h nan=%b want 2 40400000 0", index_pred, max_value, nan_seen);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle: got done=%b busy=%b want 00", done, busy);
      end
   endtask

   task automatic test_negative();
      img = '{32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 32'hBFC0_0000, 32'hC080_0000,
              32'hBF80_0000, 32'hC100_0000, 32'hBE80_0000, 32'hBF80_0000, 32'hC000_0000};
      pulse_start();
      feed(N, 1'b0, "neg");
      checks++;
      if (done !== 1'b1 || index_pred !== 4'd7 || max_value !== 32'hBE80_0000) begin
         failures++;
         $display("FAIL neg_result: got done=%b idx=%0d max=%h want 1 7 be800000", done, index_pred, max_value);
      end
      @(negedge clk);
   endtask

   // Start issued in the DONE cycle, then a +0 / -0 tie image.
   task automatic test_back_to_back();
      img = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 32'h3F00_0000,
              32'h3E80_0000, 32'h4100_0001, 32'h40A0_0000, 32'hBF80_0000, 32'h0000_0000};
      pulse_start();
      feed(N, 1'b0, "b2b_a");
      start = 1'b1;
      checks++;
      if (done !== 1'b1 || index_pred !== 4'd6 || max_value !== 32'h4100_0001) begin
         failures++;
         $display("FAIL b2b_a_result: got done=%b idx=%0d max=%h want 1 6 41000001", done, index_pred, max_value);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_rearm: got rdy=%b busy=%b done=%b want 110", in_ready, busy, done);
      end
      img = '{32'hBF80_0000, 32'hC000_0000, 32'hBE80_0000, 32'h0000_0000, 32'h8000_0000,
              32'hC040_0000, 32'hBF00_0000, 32'hC080_0000, 32'hBDCC_CCCD, 32'hC100_0000};
      feed(N, 1'b0, "b2b_b");
      checks++;
      if (done !== 1'b1 || index_pred !== 4'd3 || max_value !== 32'h0000_0000) begin
         failures++;
         $display("FAIL zero_tie: got done=%b idx=%0d max=%h want 1 3 00000000", done, index_pred, max_value);
      end
      @(negedge clk);
   endtask

   task automatic test_nan_inf();
      img = '{32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h4120_0000, 32'h3F00_0000,
              32'h7FC0_0001, 32'h4040_0000, 32'hFF80_0000, 32'h3E80_0000, 32'h7F80_0000};
      pulse_start();
      feed(N, 1'b0, "naninf");
      checks++;
      if (index_pred !== 4'd9 || max_value !== 32'h7F80_0000 || nan_seen !== 1'b1) begin
         failures++;
         $display("FAIL naninf_result: got idx=%0d max=%h nan=%b want 9 7f800000 1", index_pred, max_value, nan_seen);
      end
      @(negedge clk);
   endtask

   task automatic test_all_nan();
      img = '{32'h7FC0_0001, 32'hFFC0_0000, 32'h7F80_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
              32'h7FC0_0001, 32'h7FC0_0000, 32'hFF80_0001, 32'h7FA0_0000, 32'h7FC0_0001};
      pulse_start();
      feed(N, 1'b0, "allnan");
      checks++;
      if (index_pred !== 4'd0 || max_value !== 32'h7FC0_0000 || nan_seen !== 1'b1) begin
         failures++;
         $display("FAIL allnan_result: got idx=%0d max=%h nan=%b want 0 7fc00000 1", index_pred, max_value, nan_seen);
      end
      @(negedge clk);
   endtask

   // Valid held high in IDLE with +Inf (must not be consumed), then gaps.
   // Classes 0 and 8 tie for the max, so the lower index must win.
   task automatic test_random_valid();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h7F80_0000;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_valid: got rdy=%b busy=%b want 00", in_ready, busy);
      end
      img = '{32'h40A0_0000, 32'h3F80_0000, 32'hC000_0000, 32'h4080_0000, 32'h0000_0000,
              32'h4040_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h40A0_0000, 32'h409F_FFFF};
      pulse_start();
      feed(N, 1'b1, "rand");
      checks++;
      if (index_pred !== 4'd0 || max_value !== 32'h40A0_0000 || nan_seen !== 1'b0) begin
         failures++;
         $display("FAIL rand_result: got idx=%0d max=%h nan=%b want 0 40a00000 0", index_pred, max_value, nan_seen);
      end
      @(negedge clk);
   endtask

   task automatic test_restart();
      img = '{32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0001, 32'h4000_0000, 32'h0000_0000,
              32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      pulse_start();
      feed(4, 1'b0, "abort");
      pulse_start();
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL restart_state: got busy=%b rdy=%b done=%b want 110", busy, in_ready, done);
      end
      checks++;
      if (index_pred !== 4'd0 || max_value !== 32'h40A0_0000 || nan_seen !== 1'b0) begin
         failures++;
         $display("FAIL restart_hold: got idx=%0d max=%h nan=%b want 0 40a00000 0", index_pred, max_value, nan_seen);
      end
      img = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h40C0_0000,
              32'h4040_0000, 32'h3E80_0000, 32'h4080_0000, 32'h40BF_FFFF, 32'h0000_0000};
      feed(N, 1'b0, "restart");
      checks++;
      if (done !== 1'b1 || index_pred !== 4'd4 || max_value !== 32'h40C0_0000 || nan_seen !== 1'b0) begin
         failures++;
         $display("FAIL restart_result: got done=%b idx=%0d max=%h nan=%b want 1 4 40c00000 0",
                  done, index_pred, max_value, nan_seen);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      img = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h4040_0000,
              32'h7FC0_0001, 32'h3E80_0000, 32'h4080_0000, 32'h4100_0000, 32'h4120_0000};
      pulse_start();
      feed(6, 1'b0, "pre_rst");
      reset_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, done, nan_seen} !== 4'b0000 || index_pred !== 4'd0 || max_value !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset: got rdy=%b busy=%b done=%b nan=%b idx=%0d max=%h want all zero",
                  in_ready, busy, done, nan_seen, index_pred, max_value);
      end
      @(negedge clk);
      reset_n = 1'b1;
      pulse_start();
      feed(N, 1'b0, "post_rst");
      checks++;
      if (done !== 1'b1 || index_pred !== 4'd9 || max_value !== 32'h4120_0000 || nan_seen !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_result: got done=%b idx=%0d max=%h nan=%b want 1 9 41200000 1",
                  done, index_pred, max_value, nan_seen);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_back_to_back();
      test_nan_inf();
      test_all_nan();
      test_random_valid();
      test_restart();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
